debug_uart_tx: RTL and testbench

DEBUG_UART_TX -- requirements
Module: debug_uart_tx

---
 rtl/debug_uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_debug_uart_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx.sv
// Byte-FIFO-fed 8N1 debug UART transmitter; start bit leaves 2 edges after a push into an idle block, t_ready drops only when the FIFO is full.
// Define DEBUG_UART_TX_PARITY_EN to insert an even parity bit (8E1, 11-bit frames).
module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   t_data,
    input  logic                          t_valid,
    output logic                          t_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef DEBUG_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // FIFO state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          t_ready_q;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    fifo_head;

    // Transmit state
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          uart_tx_q;
    logic          line_d;
    logic          bit_end;
`ifdef DEBUG_UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic          unused_hi_bits;
    assign unused_hi_bits = ^t_data[31:8];

    assign push       = t_valid && t_ready_q;
    assign fifo_empty = (level_q == '0);
    assign fifo_head  = mem_q[rd_ptr_q];
    assign bit_end    = (baud_q == BAUD_LAST);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage carries no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= t_data[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        line_d    = 1'b1;
        baud_d    = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
`ifdef DEBUG_UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            START: begin
                line_d = 1'b0;
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                line_d = shift_q[0];
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef DEBUG_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef DEBUG_UART_TX_PARITY_EN
            PARITY: begin
                line_d = par_q;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                line_d = 1'b1;
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Loading the next byte is shared by IDLE and back-to-back STOP exits.
        if (pop) begin
            state_d   = START;
            shift_d   = fifo_head;
            bit_idx_d = '0;
            baud_d    = '0;
`ifdef DEBUG_UART_TX_PARITY_EN
            par_d     = ^fifo_head;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            t_ready_q <= 1'b0;
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
`ifdef DEBUG_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            t_ready_q <= (level_d != LEVEL_FULL);
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            uart_tx_q <= line_d;
`ifdef DEBUG_UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign t_ready    = t_ready_q;
    assign uart_tx    = uart_tx_q;
    assign fifo_level = level_q;
    assign busy       = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed and randomized bench for debug_uart_tx; a line decoder turns uart_tx back into frames for comparison.
module tb_debug_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef DEBUG_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] t_data = '0;
    logic        t_valid = 1'b0;
    logic        t_ready;
    logic        uart_tx;
    logic        busy;
    logic [4:0]  fifo_level;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic rst_seen = 1'b1;

    logic [10:0] rx_q[$];
    logic [7:0]  exp_q[$];
    int          start_q[$];

    int          mon_cnt = -1;
    logic [10:0] mon_bits = '0;

    debug_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .t_data     (t_data),
        .t_valid    (t_valid),
        .t_ready    (t_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Line decoder: samples each bit in its middle cycle.
    always @(negedge clk) begin
        if (rst_seen) begin
            mon_cnt = -1;
        end else begin
            if (mon_cnt < 0 && uart_tx === 1'b0) begin
                mon_cnt  = 0;
                mon_bits = '0;
                start_q.push_back(cyc);
            end
            if (mon_cnt >= 0) begin
                if (mon_cnt % CPB == CPB / 2) begin
                    mon_bits[mon_cnt / CPB] = uart_tx;
                end
                mon_cnt++;
                if (mon_cnt == FB * CPB) begin
                    rx_q.push_back(mon_bits);
                    mon_cnt = -1;
                end
            end
        end
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '0;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef DEBUG_UART_TX_PARITY_EN
        f[9]   = ^b;
        f[10]  = 1'b1;
`else
        f[9]   = 1'b1;
`endif
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, output int acc);
        bit done;
        bit rdy;
        done    = 1'b0;
        acc     = -1;
        t_valid = 1'b1;
        t_data  = w;
        for (int i = 0; i < 1000 && !done; i++) begin
            rdy = (t_ready === 1'b1);
            step();
            if (rdy) begin
                done = 1'b1;
                acc  = cyc;
                exp_q.push_back(w[7:0]);
            end
        end
        t_valid = 1'b0;
        t_data  = $urandom;
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20000 && busy !== 1'b0; i++) step();
        check("drain_idle", busy, 0);
        step();
        step();
    endtask

    task automatic check_frames(input string tag);
        logic [7:0] b;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (rx_q.size() == 0) begin
                check({tag, "_missing"}, 32'd0, 32'd1);
            end else begin
                check(tag, rx_q.pop_front(), exp_frame(b));
            end
        end
        check({tag, "_extra"}, rx_q.size(), 0);
    endtask

    initial begin
        int          acc;
        int          acc2;
        int          n_acc;
        int          first_full;
        bit          rdy;
        logic [10:0] f;
        logic [31:0] words [20];

        rst = 1'b1;
        repeat (3) step();
        check("rst_uart_tx", uart_tx, 1);
        check("rst_t_ready", t_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        rst = 1'b0;
        step();
        check("ready_after_rst", t_ready, 1);

        // Single byte: exact waveform and latency
        start_q.delete();
        push(32'h0000_0041, acc);
        check("level_after_push", fifo_level, 1);
        check("busy_queued", busy, 1);
        f = exp_frame(8'h41);
        for (int j = 1; j <= FB * CPB + 2; j++) begin
            step();
            check("wave_41", uart_tx, (j < 2 || j >= FB * CPB + 2) ? 1'b1 : f[(j - 2) / CPB]);
        end
        check("busy_after_stop", busy, 0);
        check("start_latency", (start_q.size() > 0) ? start_q[0] - acc : -1, 2);
        drain();
        check_frames("frame_41");

        // Back-to-back frames
        start_q.delete();
        push(32'h0000_0041, acc);
        push(32'h0000_0042, acc2);
        check("b2b_accept_gap", acc2 - acc, 1);
        drain();
        check("b2b_starts", start_q.size(), 2);
        if (start_q.size() == 2) check("b2b_gap", start_q[1] - start_q[0], FB * CPB);
        check_frames("frame_b2b");

        push(32'hDEAD_BE55, acc);
        drain();
        check_frames("frame_dead");

        // Random words with random gaps
        repeat (8) begin
            push($urandom, acc);
            repeat ($urandom_range(0, 60)) step();
        end
        drain();
        check_frames("frame_rand");

        // Hold t_valid with 20 distinct words to fill the FIFO
        for (int i = 0; i < 20; i++) words[i] = ($urandom << 8) | 32'((i * 37 + 11) % 256);
        n_acc      = 0;
        first_full = -1;
        t_valid    = 1'b1;
        t_data     = words[0];
        for (int c = 0; c < 5000 && n_acc < 20; c++) begin
            rdy = (t_ready === 1'b1);
            step();
            if (rdy) begin
                exp_q.push_back(words[n_acc][7:0]);
                n_acc++;
                if (n_acc < 20) t_data = words[n_acc];
                if (n_acc == 2) check("pushpop_level", fifo_level, 1);
                if (n_acc > 17) begin
                    check("ready_one_cycle", t_ready, 0);
                    check("refill_level", fifo_level, DEPTH);
                end
            end
            if (t_ready !== 1'b1 && first_full < 0) begin
                first_full = n_acc;
                check("accepted_before_full", n_acc, DEPTH + 1);
                check("full_level", fifo_level, DEPTH);
            end
        end
        t_valid = 1'b0;
        check("all_20_accepted", n_acc, 20);
        drain();
        check_frames("frame_fill");

        // Reset during data bit 3 with 5 bytes queued
        start_q.delete();
        push(32'h0000_0041, acc);
        for (int k = 0; k < 5; k++) push($urandom, acc2);
        for (int i = 0; i < 200 && start_q.size() == 0; i++) step();
        check("rst_frame_started", start_q.size(), 1);
        if (start_q.size() > 0) begin
            for (int i = 0; i < 200 && cyc < start_q[0] + 4 * CPB; i++) step();
        end
        check("pre_rst_line", uart_tx, 0);
        check("pre_rst_level", fifo_level, 5);
        rst = 1'b1;
        step();
        check("rst_mid_uart_tx", uart_tx, 1);
        check("rst_mid_level", fifo_level, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", t_ready, 0);
        rst = 1'b0;
        step();
        check("ready_after_mid_rst", t_ready, 1);
        exp_q.delete();
        repeat (FB * CPB * 3) step();
        check("no_frames_after_rst", start_q.size(), 1);
        check("no_rx_after_rst", rx_q.size(), 0);
        check("idle_line_after_rst", uart_tx, 1);
        check("idle_busy_after_rst", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
